// File: rtl/sm_scale_seq.sv
// Sequential shift-add scaler for sign-magnitude words: one coefficient term (mag >> k)
// is accumulated per cycle through a single magnitude-wide adder; the sign passes through.
module sm_scale_seq #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       NSHIFT   = 33,
  parameter logic [NSHIFT-1:0] COEF_RST = 33'h1_FBA9_C0E4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              cfg_we,
  input  logic [NSHIFT-1:0] cfg_coef,
  output logic              cfg_err,
  output logic              busy
);

  localparam int unsigned MW = WIDTH - 1;
  localparam int unsigned IW = $clog2(MW);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic              sign_q;
  logic [MW-1:0]     mag_q;
  logic [MW-1:0]     acc_q;
  logic [MW-1:0]     work_q;
  logic [NSHIFT-1:0] coef_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              cfg_err_q;

  logic [IW-1:0]     low_idx;
  logic [MW-1:0]     acc_d;
  logic [MW-1:0]     work_d;

  // Terms at k >= MW shift a MW-bit magnitude to zero, so those mask bits are never used.
  logic unused_coef;
  assign unused_coef = ^coef_q[NSHIFT-1:MW];

  always_comb begin
    low_idx = '0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (work_q[i]) low_idx = IW'(i);
    end
    acc_d  = (work_q != '0) ? acc_q + (mag_q >> low_idx) : acc_q;
    work_d = work_q & (work_q - MW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      acc_q       <= '0;
      work_q      <= '0;
      coef_q      <= COEF_RST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (cfg_we) coef_q <= cfg_coef;
          // work is loaded from the pre-write coefficient when both strobes coincide
          if (in_valid) begin
            sign_q  <= in_data[WIDTH-1];
            mag_q   <= in_data[MW-1:0];
            acc_q   <= '0;
            work_q  <= coef_q[MW-1:0];
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q  <= acc_d;
          work_q <= work_d;
          if (work_d == '0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_data_q  <= {sign_q, acc_d};
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/sm_scale_seq.md
# sm_scale_seq

Sequential shift-add scaler for 32-bit sign-magnitude words, multiplying the magnitude by a programmable fixed-point coefficient. The coefficient is a mask of right-shift terms. Instead of a wide adder tree, the block uses one 31-bit adder over several cycles: one coefficient term per cycle, sign bit carried through unchanged. It sits between sign-magnitude producers and consumers, with valid/ready on both sides and a config port for the coefficient.

## Interface
- WIDTH, 32: word width including sign bit; magnitude is WIDTH-1 bits.
- NSHIFT, 33: coefficient mask width; bit k set means term (mag >> k), k = 0..NSHIFT-1.
- COEF_RST, 33'h1_FBA9_C0E4: coefficient register reset value (≈0.30 scale).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept; high exactly when state = IDLE.
- in_data  in  WIDTH  [31] sign, [30:0] magnitude.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  [31] captured sign, [30:0] scaled magnitude.
- cfg_we  in  1  coefficient write strobe.
- cfg_coef  in  NSHIFT  new coefficient mask.
- cfg_err  out  1  one-cycle pulse: write was rejected.
- busy  out  1  state is RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, in_valid=1:
  - latch sign = in_data[31], mag = in_data[30:0], acc = 0.
  - latch work = coef[30:0]; terms with k ≥ 31 are dropped because they are zero for a 31-bit magnitude.
  - go to RUN.
- RUN, each cycle:
  - if work ≠ 0: k = index of lowest set bit; acc ← (acc + (mag >> k)) mod 2^31; clear bit k.
  - if work is zero after this step, or was already zero: go to DONE and register out_valid=1, out_data={sign, acc_next}.
- DONE: hold out_data and out_valid. On out_ready=1, clear out_valid and go to IDLE.
- Arithmetic:
  - Each term is floored on its own and taken from the original mag, never from a re-shifted value.
  - The sum wraps modulo 2^31 with no saturation and no overflow flag.
- Sign is passed through untouched; a zero result keeps sign=1 (negative zero is preserved).
- Coefficient register:
  - cfg_we=1 in IDLE loads cfg_coef at the clock edge.
  - If in_valid is high in the same cycle, that transaction uses the old coefficient.
  - cfg_we=1 in RUN or DONE is ignored; the register is unchanged and cfg_err pulses high for the next cycle.
- Reset: asserting rst_n mid-transaction aborts it. The result is discarded and the state returns to IDLE.

## Timing
- Values while rst_n is low:
  - state IDLE; in_ready=1.
  - out_valid=0, out_data=0, cfg_err=0, busy=0.
  - coef=COEF_RST, acc=0, work=0.
- Latency: let the accept edge be T and N = popcount(coef[30:0]). out_valid rises at edge T+max(N,1).
- Throughput: in_ready is low from T+1 until the edge after the out handshake. With out_ready held high, the minimum period is max(N,1)+1 cycles.
- out_valid and out_data are registered. out_data is stable throughout DONE.
- in_ready and busy are decoded directly from state, with no combinational path from in_valid or out_ready.

## Test plan
- Default coefficient, in_data=32'h0000_0064, out_ready=1 -> out_data=32'h0000_001D; out_valid at 16 cycles after accept.
- Default coefficient, in_data=32'h8000_0064 -> 32'h8000_001D. Then in_data=32'h8000_0000 -> 32'h8000_0000 (negative zero kept).
- Write cfg_coef=33'h0_0000_0003, in_data=32'h7FFF_FFFF -> 32'h3FFF_FFFE (wrap mod 2^31); latency 2.
- Coefficient mask edge cases:
  - cfg_coef=33'h0 -> out_data = {sign, 0}; latency 1.
  - cfg_coef=33'h1_8000_0000 -> magnitude 0; latency 1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0. Pulse cfg_we during DONE -> cfg_err pulses and the next result still uses the old coefficient.
- Drop rst_n during RUN -> out_valid never rises. After release: in_ready=1, coef=COEF_RST, and the next transaction is correct.
